usb_link_sched: RTL and testbench

Scheduler that shares the FT245 FIFO bridge between NReq on-chip requesters. It arbitrates the single TX frame channel (txd/flg/snt) round-robin and sequences each frame transfer, with a watchdog against lost completions. It also routes each received RX frame (rxd/rcv) to one requester by its header byte. It sits between the FT245_FIFO instance and the board's reporting and command-handling blocks.

---
 rtl/usb_link_pkg.sv | 52 +++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/usb_link_sched.sv | 173 +++++++++++++++++
 tb/tb_usb_link_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_link_pkg.sv
// usb_link_pkg: shared types, widths and the round-robin helper for the
// usb_link_sched FT245 bridge scheduler.
//   tx_state_e : TX frame sequencer states
//   frame_w()  : bytes -> bit width of a bridge frame
//   hdr_lsb()  : LSB position of the routing header byte in an RX frame
//   rr_next()  : first requester at or after ptr (ascending, wrapping)
package usb_link_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned HDR_W    = BYTE_W;
  localparam int unsigned MAX_NREQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } tx_state_e;

  function automatic int unsigned frame_w(input int unsigned nbytes);
    return BYTE_W * nbytes;
  endfunction

  // Header is the most significant byte of an RX frame.
  function automatic int unsigned hdr_lsb(input int unsigned rx_w);
    return rx_w - HDR_W;
  endfunction

  // Returns the first set req bit at or after ptr, wrapping modulo n.
  // Returns 0 when no bit is set; callers qualify with an any flag.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                         input logic [MAX_NREQ-1:0] req,
                                         input int unsigned n);
    logic [2:0] idx;
    logic [2:0] gnt;
    logic       found;
    idx   = ptr;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      if (k < n) begin
        if (!found && req[idx]) begin
          gnt   = idx;
          found = 1'b1;
        end
        idx = (idx == 3'(n - 1)) ? 3'd0 : idx + 3'd1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     : per-requester request bits
//   ptr     : index where the search starts
//   en      : qualifies any (grant only taken when enabled)
//   gnt_idx : winning index (valid when any=1)
//   any     : en and at least one request present
module rr_arbiter
  import usb_link_pkg::*;
#(
  parameter int unsigned NReq = 4
) (
  input  logic [NReq-1:0]         req,
  input  logic [$clog2(NReq)-1:0] ptr,
  input  logic                    en,
  output logic [$clog2(NReq)-1:0] gnt_idx,
  output logic                    any
);

  localparam int unsigned PW = $clog2(NReq);

  logic [MAX_NREQ-1:0] req_ext;
  logic [2:0]          ptr_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[NReq-1:0]  = req;
    ptr_ext            = '0;
    ptr_ext[PW-1:0]    = ptr;
    gnt_idx            = PW'(rr_next(ptr_ext, req_ext, NReq));
    any                = en && (|req);
  end

endmodule

// File: rtl/usb_link_sched.sv
// usb_link_sched: shares one FT245 FIFO bridge between NReq requesters.
//   TX: round-robin arbitration of req/req_dat, frame sequencing towards the
//       bridge (txd/flg, completion on snt), ack per requester, watchdog abort
//       reported on tx_err.
//   RX: each bridge frame (rxd/rcv) is routed by its header byte to one
//       requester (rx_vld one-hot, rx_dat = payload) or dropped (rx_err).
// All outputs are registered.
module usb_link_sched
  import usb_link_pkg::*;
#(
  parameter int unsigned NReq   = 4,
  parameter int unsigned TxBCnt = 2,
  parameter int unsigned RxBCnt = 5,
  parameter int unsigned ClkFrq = 200000000,
  parameter int unsigned TimOut = ClkFrq / 100
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NReq-1:0]                       req,
  input  logic [NReq*frame_w(TxBCnt)-1:0]       req_dat,
  output logic [NReq-1:0]                       ack,
  output logic                                  tx_err,
  output logic [frame_w(TxBCnt)-1:0]            txd,
  output logic                                  flg,
  input  logic                                  snt,
  input  logic [frame_w(RxBCnt)-1:0]            rxd,
  input  logic                                  rcv,
  output logic [frame_w(RxBCnt)-HDR_W-1:0]      rx_dat,
  output logic [NReq-1:0]                       rx_vld,
  output logic                                  rx_err
);

  localparam int unsigned TxW    = frame_w(TxBCnt);
  localparam int unsigned RxW    = frame_w(RxBCnt);
  localparam int unsigned HdrLsb = hdr_lsb(RxW);
  localparam int unsigned PW     = $clog2(NReq);
  localparam int unsigned WW     = $clog2(TimOut + 1);
  localparam logic [WW-1:0] WdogLim = WW'(TimOut);
  localparam logic [PW-1:0] LastIdx = PW'(NReq - 1);

  tx_state_e         state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     sel_q, sel_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [TxW-1:0]    txd_q, txd_d;
  logic              flg_q, flg_d;
  logic [NReq-1:0]   ack_q, ack_d;
  logic              tx_err_q, tx_err_d;

  logic [HdrLsb-1:0] rx_dat_q, rx_dat_d;
  logic [NReq-1:0]   rx_vld_q, rx_vld_d;
  logic              rx_err_q, rx_err_d;
  logic [HDR_W-1:0]  hdr;

  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              arb_en;
  logic [PW-1:0]     sel_inc;

  // The cycle carrying the tx_err pulse is kept out of arbitration so an
  // abort costs the same turnaround as a normal DONE cycle.
  assign arb_en  = (state_q == IDLE) && !tx_err_q;
  assign sel_inc = (sel_q == LastIdx) ? '0 : sel_q + 1'b1;

  rr_arbiter #(
    .NReq(NReq)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    wdog_d   = wdog_q;
    txd_d    = txd_q;
    flg_d    = 1'b0;
    ack_d    = '0;
    tx_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (gnt_any) begin
          sel_d   = gnt_idx;
          txd_d   = req_dat[gnt_idx*TxW +: TxW];
          flg_d   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Counting from LOAD puts wdog==TimOut exactly TimOut cycles after
        // the strobe, so the registered tx_err lands at LOAD+TimOut+1.
        wdog_d  = wdog_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (snt) begin
          ack_d[sel_q] = 1'b1;
          wdog_d       = '0;
          state_d      = DONE;
        end else if (wdog_q == WdogLim) begin
          tx_err_d = 1'b1;
          wdog_d   = '0;
          ptr_d    = sel_inc;
          state_d  = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      DONE: begin
        ptr_d   = sel_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hdr      = rxd[RxW-1 -: HDR_W];
    rx_dat_d = rx_dat_q;
    rx_vld_d = '0;
    rx_err_d = 1'b0;
    if (rcv) begin
      if (hdr < HDR_W'(NReq)) begin
        rx_dat_d              = rxd[HdrLsb-1:0];
        rx_vld_d[hdr[PW-1:0]] = 1'b1;
      end else begin
        rx_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      wdog_q   <= '0;
      txd_q    <= '0;
      flg_q    <= 1'b0;
      ack_q    <= '0;
      tx_err_q <= 1'b0;
      rx_dat_q <= '0;
      rx_vld_q <= '0;
      rx_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      wdog_q   <= wdog_d;
      txd_q    <= txd_d;
      flg_q    <= flg_d;
      ack_q    <= ack_d;
      tx_err_q <= tx_err_d;
      rx_dat_q <= rx_dat_d;
      rx_vld_q <= rx_vld_d;
      rx_err_q <= rx_err_d;
    end
  end

  assign txd    = txd_q;
  assign flg    = flg_q;
  assign ack    = ack_q;
  assign tx_err = tx_err_q;
  assign rx_dat = rx_dat_q;
  assign rx_vld = rx_vld_q;
  assign rx_err = rx_err_q;

endmodule

// File: tb/tb_usb_link_sched.sv
// Self-checking bench for usb_link_sched (NReq=4, TxBCnt=2, RxBCnt=5,
// TimOut=64). RX decoding is table-driven then randomized; TX is exercised by
// hand sequences (single frame, round-robin, watchdog, reset mid-frame) and
// randomized request masks checked against a transaction-level model.
module tb_usb_link_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_dat;
  logic [3:0]  ack;
  logic        tx_err;
  logic [15:0] txd;
  logic        flg;
  logic        snt;
  logic [39:0] rxd;
  logic        rcv;
  logic [31:0] rx_dat;
  logic [3:0]  rx_vld;
  logic        rx_err;

  always #5 clk = ~clk;

  usb_link_sched #(
    .NReq   (4),
    .TxBCnt (2),
    .RxBCnt (5),
    .ClkFrq (200000000),
    .TimOut (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_dat (req_dat),
    .ack     (ack),
    .tx_err  (tx_err),
    .txd     (txd),
    .flg     (flg),
    .snt     (snt),
    .rxd     (rxd),
    .rcv     (rcv),
    .rx_dat  (rx_dat),
    .rx_vld  (rx_vld),
    .rx_err  (rx_err)
  );

  typedef struct {
    logic [39:0] rxd;
    logic [3:0]  vld;
    logic        err;
    logic [31:0] dat;
  } rx_vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rr_ptr   = 0;
  logic [31:0] exp_rx_dat;
  logic [15:0] dat [4];
  rx_vec_t     tbl [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference arbitration: first requested index at or after ptr, wrapping.
  function automatic int rr_pick(input int ptr, input logic [3:0] mask);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (ptr + k) % 4;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = '0;
    if (i >= 0 && i < 4) v[i] = 1'b1;
    return v;
  endfunction

  task automatic pack_dat;
    for (int i = 0; i < 4; i++) req_dat[i*16 +: 16] = dat[i];
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    snt   = 1'b0;
    rcv   = 1'b0;
    tick;
    tick;
    rst_n      = 1'b1;
    rr_ptr     = 0;
    exp_rx_dat = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txd"},    64'(txd),    64'd0);
    chk({tag, "_flg"},    64'(flg),    64'd0);
    chk({tag, "_ack"},    64'(ack),    64'd0);
    chk({tag, "_tx_err"}, 64'(tx_err), 64'd0);
    chk({tag, "_rx_dat"}, 64'(rx_dat), 64'd0);
    chk({tag, "_rx_vld"}, 64'(rx_vld), 64'd0);
    chk({tag, "_rx_err"}, 64'(rx_err), 64'd0);
  endtask

  task automatic wait_flg(input int lim, output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b0;
    while (cnt < lim && !ok) begin
      tick;
      cnt++;
      if (flg) ok = 1'b1;
    end
  endtask

  // One frame: expect flg `gap` cycles from now carrying dat[idx], complete
  // it with snt after `delay` WAIT cycles, expect ack[idx] the next cycle.
  task automatic run_frame(input int idx, input int delay, input int gap, input bit drop);
    int cnt;
    bit ok;
    wait_flg(12, cnt, ok);
    chk("flg_seen", 64'(ok), 64'd1);
    if (gap > 0) chk("flg_gap", 64'(cnt), 64'(gap));
    chk("txd", 64'(txd), 64'(dat[idx]));
    tick;
    chk("flg_one_cycle", 64'(flg), 64'd0);
    if (drop) req = '0;
    repeat (delay - 1) tick;
    snt = 1'b1;
    tick;
    snt = 1'b0;
    chk("ack", 64'(ack), 64'(onehot(idx)));
    chk("no_tx_err", 64'(tx_err), 64'd0);
    rr_ptr = (idx + 1) % 4;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         cnt;
    int         ack_seen;
    bit         ok;
    bit         seen;
    int         exp_idx;
    logic [3:0] mask;
    logic [7:0] hdr;
    logic [31:0] pay;
    logic [3:0] evld;
    logic       eerr;

    tbl[0] = '{40'h01_DEADBEEF, 4'b0010, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{40'h07_DEADBEEF, 4'b0000, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{40'h00_12345678, 4'b0001, 1'b0, 32'h12345678};
    tbl[3] = '{40'h03_CAFEF00D, 4'b1000, 1'b0, 32'hCAFEF00D};
    tbl[4] = '{40'h04_0BADF00D, 4'b0000, 1'b1, 32'hCAFEF00D};
    tbl[5] = '{40'h02_00000000, 4'b0100, 1'b0, 32'h00000000};
    tbl[6] = '{40'hFF_FFFFFFFF, 4'b0000, 1'b1, 32'h00000000};

    rxd = '0;
    for (int i = 0; i < 4; i++) dat[i] = 16'h0;
    pack_dat();
    do_reset();
    check_reset_outputs("reset");

    // RX vectors
    for (int v = 0; v < 7; v++) begin
      rxd = tbl[v].rxd;
      rcv = 1'b1;
      tick;
      rcv = 1'b0;
      chk("rx_tbl_vld", 64'(rx_vld), 64'(tbl[v].vld));
      chk("rx_tbl_err", 64'(rx_err), 64'(tbl[v].err));
      chk("rx_tbl_dat", 64'(rx_dat), 64'(tbl[v].dat));
      tick;
      chk("rx_tbl_vld_pulse", 64'(rx_vld), 64'd0);
    end

    // Single frame from requester 2
    do_reset();
    dat[2] = 16'hA55A;
    pack_dat();
    req = 4'b0100;
    run_frame(2, 20, 1, 1'b0);
    req = '0;
    tick;
    chk("ack_one_cycle", 64'(ack), 64'd0);

    // Round-robin with all requesters active
    do_reset();
    for (int i = 0; i < 4; i++) dat[i] = 16'h1000 + 16'(i * 16'h0111);
    pack_dat();
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_idx = rr_pick(rr_ptr, req);
      run_frame(exp_idx, 10, (f == 0) ? 1 : 2, 1'b0);
    end
    req = '0;

    // Watchdog abort, then the next requester is served
    do_reset();
    dat[0] = 16'hBEEF;
    dat[1] = 16'h5AA5;
    pack_dat();
    req = 4'b0011;
    wait_flg(12, cnt, ok);
    chk("wd_flg_seen", 64'(ok), 64'd1);
    chk("wd_txd", 64'(txd), 64'(dat[rr_pick(rr_ptr, req)]));
    cnt      = 0;
    seen     = 1'b0;
    ack_seen = 0;
    while (cnt < 100 && !seen) begin
      tick;
      cnt++;
      if (ack != 4'b0) ack_seen++;
      if (tx_err) seen = 1'b1;
    end
    chk("wd_tx_err_seen", 64'(seen), 64'd1);
    chk("wd_latency", 64'(cnt), 64'd65);
    chk("wd_no_ack", 64'(ack_seen), 64'd0);
    tick;
    chk("wd_tx_err_one_cycle", 64'(tx_err), 64'd0);
    rr_ptr  = 1;
    exp_idx = rr_pick(rr_ptr, req);
    wait_flg(12, cnt, ok);
    chk("wd_next_flg_gap", 64'(cnt), 64'd1);
    chk("wd_next_txd", 64'(txd), 64'(dat[exp_idx]));
    repeat (4) tick;
    // snt and rcv in the same cycle
    snt = 1'b1;
    rcv = 1'b1;
    rxd = 40'h02_11223344;
    tick;
    snt = 1'b0;
    rcv = 1'b0;
    req = '0;
    exp_rx_dat = 32'h11223344;
    chk("both_ack", 64'(ack), 64'(onehot(exp_idx)));
    chk("both_rx_vld", 64'(rx_vld), 64'b0100);
    chk("both_rx_dat", 64'(rx_dat), 64'(exp_rx_dat));
    rr_ptr = (exp_idx + 1) % 4;

    // Reset during WAIT, stale snt ignored, then a fresh frame
    req = 4'b0010;
    wait_flg(12, cnt, ok);
    chk("rw_flg_seen", 64'(ok), 64'd1);
    chk("rw_txd", 64'(txd), 64'(dat[1]));
    repeat (3) tick;
    rst_n = 1'b0;
    req   = '0;
    tick;
    check_reset_outputs("midreset");
    rst_n      = 1'b1;
    rr_ptr     = 0;
    exp_rx_dat = '0;
    repeat (3) tick;
    snt = 1'b1;
    tick;
    snt = 1'b0;
    chk("stale_snt_no_ack", 64'(ack), 64'd0);
    chk("stale_snt_no_flg", 64'(flg), 64'd0);
    dat[0] = 16'h0F0F;
    pack_dat();
    req = 4'b0001;
    run_frame(0, 4, 1, 1'b0);
    req = '0;

    // Randomized TX masks
    repeat (3) tick;
    for (int f = 0; f < 20; f++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
      pack_dat();
      req     = mask;
      exp_idx = rr_pick(rr_ptr, mask);
      run_frame(exp_idx, int'($urandom_range(1, 20)), (f == 0) ? 1 : 2, (f % 4) == 3);
    end
    req = '0;
    tick;

    // Randomized RX frames
    for (int f = 0; f < 40; f++) begin
      hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      pay = $urandom;
      rxd = {hdr, pay};
      rcv = 1'b1;
      tick;
      rcv = 1'b0;
      if (hdr < 8'd4) begin
        evld       = onehot(int'(hdr));
        eerr       = 1'b0;
        exp_rx_dat = pay;
      end else begin
        evld = '0;
        eerr = 1'b1;
      end
      chk("rx_rand_vld", 64'(rx_vld), 64'(evld));
      chk("rx_rand_err", 64'(rx_err), 64'(eerr));
      chk("rx_rand_dat", 64'(rx_dat), 64'(exp_rx_dat));
      if (f % 5 == 0) begin
        tick;
        chk("rx_rand_idle_vld", 64'(rx_vld), 64'd0);
        chk("rx_rand_idle_err", 64'(rx_err), 64'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
